// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini SRC control unit, fetch T0-T2 then decoded execute T3-T6.
module control_sequencer #(
  parameter logic [4:0] PC_INC_OP = 5'b11111
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  output logic [4:0]  alu_control,
  output logic [15:0] reg_en,
  output logic [15:0] reg_out,
  output logic        Pout,
  output logic        Pen,
  output logic        MARen,
  output logic        MDRen,
  output logic        MDROut,
  output logic        Read,
  output logic        IRen,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIen,
  output logic        LOen,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        run,
  output logic        instr_done
);
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t state, nxt;
  logic [4:0] op, imm_alu;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic rfmt, imm, md, nn, mfhi, mflo, halt_op;
  assign op      = ir[31:27];
  assign ra_oh   = 16'd1 << ir[26:23];
  assign rb_oh   = 16'd1 << ir[22:19];
  assign rc_oh   = 16'd1 << ir[18:15];
  assign rfmt    = op >= 5'd3 && op <= 5'd11;
  assign imm     = op >= 5'd12 && op <= 5'd14;
  assign md      = op == 5'd15 || op == 5'd16;
  assign nn      = op == 5'd17 || op == 5'd18;
  assign mfhi    = op == 5'd24;
  assign mflo    = op == 5'd25;
  assign halt_op = op == 5'd27;
  // Immediate forms reuse the add/and/or ALU codes
  assign imm_alu = op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd10 : 5'd11;
  assign run     = state != RST && state != HALT;
  always_ff @(posedge clk)
    state <= clr ? RST : nxt;
  always_comb begin
    nxt = state;
    alu_control = '0;
    reg_en = '0;
    reg_out = '0;
    {Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen} = '0;
    {ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout, Cout} = '0;
    instr_done = 1'b0;
    case (state)
      RST: nxt = T0;
      T0: begin
        {Pout, MARen, ZLOen} = '1;
        alu_control = PC_INC_OP;
        nxt = T1;
      end
      T1: begin
        {ZLOout, Pen, Read, MDRen} = '1;
        nxt = T2;
      end
      T2: begin
        {MDROut, IRen} = '1;
        nxt = T3;
      end
      T3: begin
        if (rfmt || imm || md) begin
          reg_out = md ? ra_oh : rb_oh;
          Yen = 1'b1;
          nxt = T4;
        end else if (nn) begin
          reg_out = rb_oh;
          ZLOen = 1'b1;
          alu_control = op;
          nxt = T4;
        end else begin
          instr_done = 1'b1;
          HIout = mfhi;
          LOout = mflo;
          reg_en = (mfhi || mflo) ? ra_oh : '0;
          nxt = halt_op ? HALT : T0;
        end
      end
      T4: begin
        if (nn) begin
          ZLOout = 1'b1;
          reg_en = ra_oh;
          instr_done = 1'b1;
          nxt = T0;
        end else begin
          ZLOen = 1'b1;
          ZHIen = md;
          Cout = imm;
          reg_out = md ? rb_oh : imm ? '0 : rc_oh;
          alu_control = imm ? imm_alu : op;
          nxt = T5;
        end
      end
      T5: begin
        ZLOout = 1'b1;
        LOen = md;
        reg_en = md ? '0 : ra_oh;
        instr_done = !md;
        nxt = md ? T6 : T0;
      end
      T6: begin
        {ZHIout, HIen, instr_done} = '1;
        nxt = T0;
      end
      HALT: nxt = HALT;
      default: nxt = RST;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random instruction streams checked against a per-instruction cycle table.
module tb_control_sequencer;
  typedef struct packed {
    logic [4:0] alu;
    logic [15:0] ren, rout;
    logic Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
    logic ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout, Cout;
    logic run, done;
  } ob_t;
  logic clk = 0, clr = 1;
  logic [31:0] ir = '0;
  logic [4:0] alu_control;
  logic [15:0] reg_en, reg_out;
  logic Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
  logic ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout, Cout;
  logic run, instr_done;
  ob_t obs, z;
  ob_t exp_q[$];
  int checks = 0, failures = 0;
  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .alu_control(alu_control), .reg_en(reg_en), .reg_out(reg_out),
    .Pout(Pout), .Pen(Pen), .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut), .Read(Read), .IRen(IRen),
    .Yen(Yen), .ZLOen(ZLOen), .ZHIen(ZHIen), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIen(HIen),
    .LOen(LOen), .HIout(HIout), .LOout(LOout), .Cout(Cout), .run(run), .instr_done(instr_done)
  );
  assign obs = {alu_control, reg_en, reg_out, Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen,
                ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, HIout, LOout, Cout, run, instr_done};
  assign z = '0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic model(input logic [31:0] i);
    logic [4:0] op = i[31:27];
    logic [15:0] a = 16'd1 << i[26:23];
    logic [15:0] b = 16'd1 << i[22:19];
    logic [15:0] c = 16'd1 << i[18:15];
    ob_t w;
    exp_q.delete();
    w = '0; w.run = 1; w.Pout = 1; w.MARen = 1; w.ZLOen = 1; w.alu = 5'b11111; exp_q.push_back(w);
    w = '0; w.run = 1; w.ZLOout = 1; w.Pen = 1; w.Read = 1; w.MDRen = 1; exp_q.push_back(w);
    w = '0; w.run = 1; w.MDROut = 1; w.IRen = 1; exp_q.push_back(w);
    if (op inside {[5'd3:5'd14]}) begin
      w = '0; w.run = 1; w.rout = b; w.Yen = 1; exp_q.push_back(w);
      w = '0; w.run = 1; w.ZLOen = 1;
      if (op < 5'd12) begin w.rout = c; w.alu = op; end
      else begin w.Cout = 1; w.alu = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd10 : 5'd11; end
      exp_q.push_back(w);
      w = '0; w.run = 1; w.ZLOout = 1; w.ren = a; w.done = 1; exp_q.push_back(w);
    end else if (op == 5'd15 || op == 5'd16) begin
      w = '0; w.run = 1; w.rout = a; w.Yen = 1; exp_q.push_back(w);
      w = '0; w.run = 1; w.rout = b; w.ZLOen = 1; w.ZHIen = 1; w.alu = op; exp_q.push_back(w);
      w = '0; w.run = 1; w.ZLOout = 1; w.LOen = 1; exp_q.push_back(w);
      w = '0; w.run = 1; w.ZHIout = 1; w.HIen = 1; w.done = 1; exp_q.push_back(w);
    end else if (op == 5'd17 || op == 5'd18) begin
      w = '0; w.run = 1; w.rout = b; w.ZLOen = 1; w.alu = op; exp_q.push_back(w);
      w = '0; w.run = 1; w.ZLOout = 1; w.ren = a; w.done = 1; exp_q.push_back(w);
    end else begin
      w = '0; w.run = 1; w.done = 1;
      if (op == 5'd24) begin w.HIout = 1; w.ren = a; end
      if (op == 5'd25) begin w.LOout = 1; w.ren = a; end
      exp_q.push_back(w);
    end
  endtask
  task automatic step(input ob_t e, input string tag);
    int drv = $countones({reg_out, Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout});
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    checks++;
    assert (drv <= 1 && $countones(reg_en) <= 1) else begin
      failures++;
      $error("FAIL %s_bus drivers=%0d reg_en=%h required single driver", tag, drv, reg_en);
    end
    @(posedge clk); #1;
  endtask
  task automatic run_instr(input logic [31:0] i, input string tag);
    ir = i;
    model(i);
    foreach (exp_q[k]) step(exp_q[k], tag);
  endtask
  initial begin
    logic [4:0] op;
    @(posedge clk); #1;
    step(z, "clr_hold");
    clr = 0;
    step(z, "rst");
    checks++;
    assert (alu_control === 5'b11111 && Pout && MARen && ZLOen) else begin
      failures++;
      $error("FAIL t0 alu=%b Pout=%b MARen=%b ZLOen=%b required 11111 1 1 1", alu_control, Pout, MARen, ZLOen);
    end
    run_instr(32'h28918000, "shr");
    run_instr({5'b01101, 4'd5, 4'd6, 19'd0}, "andi");
    run_instr({5'b01111, 4'd4, 4'd7, 19'd0}, "mul");
    run_instr({5'd3, 4'd9, 4'd1, 4'd2, 15'd0}, "add");
    model({5'd3, 4'd9, 4'd1, 4'd2, 15'd0});
    for (int k = 0; k < 4; k++) step(exp_q[k], "add_pre_clr");
    clr = 1;
    step(exp_q[4], "add_t4_clr");
    clr = 0;
    step(z, "mid_clr_rst");
    run_instr(32'hf8000000, "unlisted");
    for (int n = 0; n < 40; n++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
      run_instr({op, 27'($urandom)}, "rand");
    end
    run_instr({5'd27, 27'($urandom)}, "halt");
    for (int k = 0; k < 20; k++) step(z, "halted");
    clr = 1;
    step(z, "halt_clr");
    clr = 0;
    step(z, "halt_rst");
    run_instr({5'd26, 27'd0}, "nop");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
